// File: rtl/bus_controller_pkg.sv
// Shared definitions for the bus controller: opcodes and FSM state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bus_ctrl_pkg;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

endpackage

// File: rtl/bus_controller_if.sv
// Bus-control interface: Run/Instr request in, bus-driver/load/ALU enables out.
// Latency: n/a (wiring only).
// Backpressure: none; Busy tells the requester when Run will be ignored.
// master: requester side (drives Run/Instr). slave: the controller.
interface bus_controller_if #(
    parameter int SEL_W = 2
) ();
    localparam int NUM_REGS = 2 ** SEL_W;
    localparam int IR_W     = 2 + 2 * SEL_W;

    logic                Run;
    logic [IR_W-1:0]     Instr;
    logic [NUM_REGS-1:0] R_out;
    logic                DIN_out;
    logic                G_out;
    logic [NUM_REGS-1:0] R_in;
    logic                A_in;
    logic                G_in;
    logic                AddSub;
    logic                Busy;
    logic                Done;

    modport master (
        output Run, Instr,
        input  R_out, DIN_out, G_out, R_in, A_in, G_in, AddSub, Busy, Done
    );

    modport slave (
        input  Run, Instr,
        output R_out, DIN_out, G_out, R_in, A_in, G_in, AddSub, Busy, Done
    );
endinterface

// File: rtl/bus_controller_dec_onehot.sv
// Binary select to one-hot decoder with enable; all-zero when disabled.
// Latency: combinational.
// Backpressure: none.
// Ports: en (enable), sel (binary index), onehot (decoded vector).
module dec_onehot #(
    parameter int SEL_W    = 2,
    parameter int NUM_REGS = 2 ** SEL_W
) (
    input  logic                en,
    input  logic [SEL_W-1:0]    sel,
    output logic [NUM_REGS-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end
endmodule

// File: rtl/bus_controller.sv
// Control FSM for the shared 4-bit datapath bus: captures an instruction on Run
// and issues one-hot bus-driver, load and ALU enables. Latency: mv/mvi Done 1
// cycle after Run is sampled, add/sub 3 cycles. Backpressure: Run ignored while Busy.
// Ports: Clock, Reset (sync, active-high), bus (slave modport of bus_controller_if).
module bus_controller
    import bus_ctrl_pkg::*;
#(
    parameter int SEL_W    = 2,
    parameter int NUM_REGS = 2 ** SEL_W
) (
    input  logic           Clock,
    input  logic           Reset,
    bus_controller_if.slave bus
);
    localparam int IR_W = 2 + 2 * SEL_W;

    state_t              state_q, state_d;
    logic [IR_W-1:0]     ir_q, ir_d;

    logic [NUM_REGS-1:0] r_out_q, r_out_d;
    logic [NUM_REGS-1:0] r_in_q, r_in_d;
    logic                din_out_q, din_out_d;
    logic                g_out_q, g_out_d;
    logic                a_in_q, a_in_d;
    logic                g_in_q, g_in_d;
    logic                addsub_q, addsub_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [1:0]          op_cur;
    logic [1:0]          op_nxt;
    logic [SEL_W-1:0]    x_nxt, y_nxt, src_sel;
    logic                arith_nxt;
    logic                src_en, dst_en;

    assign op_cur = ir_q[IR_W-1 -: 2];

    // Next state / next IR.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE: begin
                if (bus.Run) begin
                    ir_d    = bus.Instr;
                    state_d = T1;
                end
            end
            T1:      state_d = (op_cur == OP_MV || op_cur == OP_MVI) ? IDLE : T2;
            T2:      state_d = T3;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the state/IR being entered and then registered,
    // so they are glitch-free Moore outputs aligned with the state they describe.
    assign op_nxt    = ir_d[IR_W-1 -: 2];
    assign x_nxt     = ir_d[2*SEL_W-1 -: SEL_W];
    assign y_nxt     = ir_d[SEL_W-1:0];
    assign arith_nxt = (op_nxt == OP_ADD) || (op_nxt == OP_SUB);

    // Source register is X only while fetching the first ALU operand.
    assign src_sel = (state_d == T1 && arith_nxt) ? x_nxt : y_nxt;
    assign src_en  = (state_d == T1 && op_nxt != OP_MVI) || (state_d == T2);
    assign dst_en  = (state_d == T1 && !arith_nxt) || (state_d == T3);

    dec_onehot #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_dec_src (
        .en     (src_en),
        .sel    (src_sel),
        .onehot (r_out_d)
    );

    dec_onehot #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_dec_dst (
        .en     (dst_en),
        .sel    (x_nxt),
        .onehot (r_in_d)
    );

    always_comb begin
        din_out_d = (state_d == T1) && (op_nxt == OP_MVI);
        g_out_d   = (state_d == T3);
        a_in_d    = (state_d == T1) && arith_nxt;
        g_in_d    = (state_d == T2);
        addsub_d  = (state_d == T2) && ir_d[IR_W-2];
        busy_d    = (state_d != IDLE);
        done_d    = dst_en;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            r_out_q   <= '0;
            r_in_q    <= '0;
            din_out_q <= 1'b0;
            g_out_q   <= 1'b0;
            a_in_q    <= 1'b0;
            g_in_q    <= 1'b0;
            addsub_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            r_out_q   <= r_out_d;
            r_in_q    <= r_in_d;
            din_out_q <= din_out_d;
            g_out_q   <= g_out_d;
            a_in_q    <= a_in_d;
            g_in_q    <= g_in_d;
            addsub_q  <= addsub_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.R_out   = r_out_q;
    assign bus.R_in    = r_in_q;
    assign bus.DIN_out = din_out_q;
    assign bus.G_out   = g_out_q;
    assign bus.A_in    = a_in_q;
    assign bus.G_in    = g_in_q;
    assign bus.AddSub  = addsub_q;
    assign bus.Busy    = busy_q;
    assign bus.Done    = done_q;
endmodule

// File: tb/tb_bus_controller.sv
// Directed-vector bench for bus_controller with a small 4-bit datapath model
// and a random bus-invariant monitor.
module tb_bus_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_controller_if #(.SEL_W(2)) bif ();

    bus_controller #(.SEL_W(2), .NUM_REGS(4)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bif.slave)
    );

    int checks = 0;
    int failures = 0;

    // Output word: R_out[4] DIN_out G_out R_in[4] A_in G_in AddSub Busy Done
    function automatic logic [14:0] outs();
        return {bif.R_out, bif.DIN_out, bif.G_out, bif.R_in,
                bif.A_in, bif.G_in, bif.AddSub, bif.Busy, bif.Done};
    endfunction

    typedef struct {
        logic        rst;
        logic        run;
        logic [5:0]  instr;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic r, input logic rn, input logic [5:0] in,
                                input logic [14:0] e);
        vec_t v;
        v.rst = r; v.run = rn; v.instr = in; v.exp = e;
        return v;
    endfunction

    task automatic step(input logic r, input logic rn, input logic [5:0] in);
        rst       = r;
        bif.Run   = rn;
        bif.Instr = in;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference datapath driven by the controller's enables.
    logic [3:0] dp_r[4];
    logic [3:0] dp_a, dp_g, din;
    always @(posedge clk) begin
        logic [3:0] busv;
        busv = 4'h0;
        for (int k = 0; k < 4; k++)
            if (bif.R_out[k] === 1'b1) busv = dp_r[k];
        if (bif.DIN_out === 1'b1) busv = din;
        if (bif.G_out === 1'b1) busv = dp_g;
        for (int k = 0; k < 4; k++)
            if (bif.R_in[k] === 1'b1) dp_r[k] <= busv;
        if (bif.A_in === 1'b1) dp_a <= busv;
        if (bif.G_in === 1'b1) dp_g <= (bif.AddSub === 1'b1) ? dp_a - busv : dp_a + busv;
    end

    initial begin
        rst = 1'b1;
        bif.Run = 1'b0;
        bif.Instr = '0;
        din = 4'h0;

        //                 rst  run  instr       rrrr_dg_iiii_aGsbd
        vecs[0]  = mk(1'b1, 1'b1, 6'b01_10_00, 15'b0000_00_0000_00000);
        vecs[1]  = mk(1'b1, 1'b1, 6'b01_10_00, 15'b0000_00_0000_00000);
        vecs[2]  = mk(1'b0, 1'b1, 6'b01_10_00, 15'b0000_10_0100_00011); // mvi R2
        vecs[3]  = mk(1'b0, 1'b0, 6'b00_00_00, 15'b0000_00_0000_00000);
        vecs[4]  = mk(1'b0, 1'b1, 6'b00_01_11, 15'b1000_00_0010_00011); // mv R1,R3
        vecs[5]  = mk(1'b0, 1'b0, 6'b00_00_00, 15'b0000_00_0000_00000);
        vecs[6]  = mk(1'b0, 1'b1, 6'b10_00_11, 15'b0001_00_0000_10010); // add R0,R3 T1
        vecs[7]  = mk(1'b0, 1'b0, 6'b00_00_00, 15'b1000_00_0000_01010); // T2
        vecs[8]  = mk(1'b0, 1'b0, 6'b00_00_00, 15'b0000_01_0001_00011); // T3
        vecs[9]  = mk(1'b0, 1'b0, 6'b00_00_00, 15'b0000_00_0000_00000);
        vecs[10] = mk(1'b0, 1'b1, 6'b11_01_01, 15'b0010_00_0000_10010); // sub R1,R1 T1
        vecs[11] = mk(1'b0, 1'b1, 6'b01_11_00, 15'b0010_00_0000_01110); // Run ignored
        vecs[12] = mk(1'b0, 1'b1, 6'b00_00_00, 15'b0000_01_0010_00011); // Run ignored
        vecs[13] = mk(1'b0, 1'b0, 6'b00_00_00, 15'b0000_00_0000_00000);
        vecs[14] = mk(1'b0, 1'b1, 6'b01_00_00, 15'b0000_10_0001_00011); // mvi R0
        vecs[15] = mk(1'b0, 1'b1, 6'b00_10_10, 15'b0000_00_0000_00000); // Run in T1 ignored
        vecs[16] = mk(1'b0, 1'b1, 6'b00_10_10, 15'b0100_00_0100_00011); // mv R2,R2
        vecs[17] = mk(1'b0, 1'b0, 6'b00_00_00, 15'b0000_00_0000_00000);
        vecs[18] = mk(1'b0, 1'b1, 6'b11_01_10, 15'b0010_00_0000_10010); // sub R1,R2 T1
        vecs[19] = mk(1'b0, 1'b0, 6'b00_00_00, 15'b0100_00_0000_01110); // T2
        vecs[20] = mk(1'b1, 1'b0, 6'b00_00_00, 15'b0000_00_0000_00000); // abort
        vecs[21] = mk(1'b0, 1'b0, 6'b00_00_00, 15'b0000_00_0000_00000);
        vecs[22] = mk(1'b1, 1'b1, 6'b01_10_00, 15'b0000_00_0000_00000); // reset beats Run
        vecs[23] = mk(1'b0, 1'b0, 6'b00_00_00, 15'b0000_00_0000_00000);

        for (int i = 0; i < 24; i++) begin
            step(vecs[i].rst, vecs[i].run, vecs[i].instr);
            check($sformatf("vec%0d", i), {17'd0, outs()}, {17'd0, vecs[i].exp});
        end

        // add with modulo-16 wrap: R0=9, R3=9, add R0,R3 -> R0=2; then sub -> 9.
        din = 4'd9;
        step(1'b0, 1'b1, 6'b01_00_00);
        step(1'b0, 1'b0, 6'b00_00_00);
        step(1'b0, 1'b1, 6'b01_11_00);
        step(1'b0, 1'b0, 6'b00_00_00);
        din = 4'd0;
        step(1'b0, 1'b1, 6'b10_00_11);
        // Instr changes while busy must not disturb the held IR.
        step(1'b0, 1'b0, 6'b01_01_01);
        step(1'b0, 1'b0, 6'b01_01_01);
        step(1'b0, 1'b0, 6'b00_00_00);
        check("add_wrap_r0", {28'd0, dp_r[0]}, 32'd2);
        check("add_r3_kept", {28'd0, dp_r[3]}, 32'd9);
        step(1'b0, 1'b1, 6'b11_00_11);
        step(1'b0, 1'b0, 6'b00_00_00);
        step(1'b0, 1'b0, 6'b00_00_00);
        step(1'b0, 1'b0, 6'b00_00_00);
        check("sub_wrap_r0", {28'd0, dp_r[0]}, 32'd9);

        // Random bus-invariant monitor.
        for (int n = 0; n < 1000; n++) begin
            step(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), 6'($urandom));
            check("bus_onehot", {31'd0, ($countones({bif.R_out, bif.DIN_out, bif.G_out}) <= 1)}, 32'd1);
            check("rin_onehot", {31'd0, ($countones(bif.R_in) <= 1)}, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_controller.md
Name: bus_controller

Overview:
Control unit for the 4-bit CPU shared data bus. Captures a 6-bit instruction on a Run request and steps through a small state machine. Each cycle it drives the one-hot tristate-buffer enables that select the single bus driver (R0..R3, DIN or G), plus register load enables and ALU add/sub control. Done signals completion. This block is the only source of bus-driver enables in the datapath.

Parameters:
SEL_W, 2, width of register-select fields in the instruction.
NUM_REGS, 4, number of general registers (2**SEL_W); enable vectors are NUM_REGS wide.

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high; returns block to IDLE
Run  input  1  start request, sampled only in IDLE
Instr  input  6  instruction: [5:4] opcode, [3:2] X (dest), [1:0] Y (src)
R_out  output  NUM_REGS  one-hot tristate enables, register k drives bus
DIN_out  output  1  tristate enable, external DIN drives bus
G_out  output  1  tristate enable, ALU result register G drives bus
R_in  output  NUM_REGS  register load enables, load from bus at next edge
A_in  output  1  load ALU operand register A from bus
G_in  output  1  load G with ALU result
AddSub  output  1  ALU op: 0 add, 1 sub
Busy  output  1  high in any state other than IDLE
Done  output  1  one-cycle pulse in the last cycle of an instruction

Behaviour:
- Opcodes: 00 mv Rx<-Ry; 01 mvi Rx<-DIN; 10 add Rx<-Rx+Ry; 11 sub Rx<-Rx-Ry. The datapath does arithmetic at 4 bits, modulo 16, with no flags.
- States: IDLE, T1, T2, T3, binary encoded. IR is a 6-bit internal register.
- IDLE: all enables 0, Busy=0. If Run=1, IR<=Instr and next state is T1. Otherwise stay in IDLE.
- T1, mv: R_out[Y]=1, R_in[X]=1, Done=1. Next state IDLE.
- T1, mvi: DIN_out=1, R_in[X]=1, Done=1. Next state IDLE.
- T1, add/sub: R_out[X]=1, A_in=1. Next state T2.
- T2, add/sub: R_out[Y]=1, G_in=1, AddSub=IR[4]. Next state T3.
- T3: G_out=1, R_in[X]=1, Done=1. Next state IDLE.
- All outputs are Moore outputs decoded from state and IR. No output depends combinationally on Run or Instr.
- Bus invariant: every cycle, at most one of {R_out bits, DIN_out, G_out} is 1. R_in is at most one-hot.
- Latency, counted from the Run-sampling edge: mv/mvi assert Done 1 cycle later; add/sub assert Done 3 cycles later.
- Back-to-back: Run in the cycle after Done is accepted (IDLE). There is no turnaround gap beyond the IDLE cycle.
- Run while Busy=1 is ignored. Instr changes while Busy=1 have no effect, because IR is held.
- X==Y is legal. Example: mv R2,R2 drives R2 and loads R2. add R1,R1 doubles R1.
- Reset is synchronous and active-high. At the next edge: state=IDLE, IR=0, and every output is 0.
- Reset mid-instruction aborts the instruction with no Done pulse. Partial register updates already committed remain.
- Reset has priority over Run in the same cycle.

Decomposition:
- Shared package bus_ctrl_pkg holds:
  - opcode constants OP_MV=2'b00, OP_MVI=2'b01, OP_ADD=2'b10, OP_SUB=2'b11;
  - state encoding IDLE=0, T1=1, T2=2, T3=3.
- One sub-module, dec_onehot: SEL_W to NUM_REGS one-hot decoder with an enable input. It is instantiated twice: once for X, driving R_in, and once for the R_out source select (X in T1 of add/sub, Y otherwise).

Test Plan:
- Reset: hold Reset=1 for 2 cycles with Run=1 -> state IDLE, all enables 0, Busy=0, Done=0.
- mvi: Run=1, Instr=6'b01_10_00 -> next cycle DIN_out=1, R_in=4'b0100, Done=1; following cycle all outputs 0.
- mv: Instr=6'b00_01_11 -> T1: R_out=4'b1000, R_in=4'b0010, Done=1.
- add R0,R3: Instr=6'b10_00_11 -> T1 R_out=0001,A_in=1; T2 R_out=1000,G_in=1,AddSub=0; T3 G_out=1,R_in=0001,Done=1. With R0=9, R3=9 loaded via DIN, R0 ends at 2 (wrap).
- sub plus Run while busy: Instr=6'b11_01_01 -> AddSub=1 in T2. Run pulsed in T2 with a different Instr -> ignored, exactly one Done. Reset asserted in T2 of a second sub -> IDLE next cycle, no Done.
- Invariant monitor over 1000 random Run/Instr cycles: popcount({R_out,DIN_out,G_out})<=1 and popcount(R_in)<=1 every cycle.
